path_arbiter: RTL and testbench

- Shares one Path ALU datapath (operands A/B, 4-bit op, mode bit s, 9-bit result y) between two requesters.
- Accepts an operation from one requester at a time via valid/ready, holds the operands on the datapath for a fixed latency, captures y, and returns it on a per-requester response handshake.
- Round-robin grant between requesters; sits between the requester logic and the Path instance.

---
 rtl/path_arbiter.sv | 171 +++++++++++++++++
 tb/tb_path_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_arbiter.sv
`timescale 1ns/1ps
// path_arbiter: shares one Path ALU datapath between two requesters.
// Grant is round-robin. Operands are held on the datapath for DP_LAT+1 edges.
// The result is then returned on the winning requester's response handshake.
// Optional feature macro: PATH_ARB_STATS_EN adds saturating response counters cnt0/cnt1.
module path_arbiter #(
  parameter int unsigned DW     = 8,
  parameter int unsigned OPW    = 4,
  parameter int unsigned DP_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [DW-1:0]  r0_a,
  input  logic [DW-1:0]  r0_b,
  input  logic [OPW-1:0] r0_op,
  input  logic           r0_s,
  output logic           r0_rvalid,
  input  logic           r0_rready,
  output logic [DW:0]    r0_y,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [DW-1:0]  r1_a,
  input  logic [DW-1:0]  r1_b,
  input  logic [OPW-1:0] r1_op,
  input  logic           r1_s,
  output logic           r1_rvalid,
  input  logic           r1_rready,
  output logic [DW:0]    r1_y,
  output logic [DW-1:0]  dp_inA,
  output logic [DW-1:0]  dp_inB,
  output logic [OPW-1:0] dp_op,
  output logic           dp_s,
  input  logic [DW:0]    dp_y,
`ifdef PATH_ARB_STATS_EN
  output logic [15:0]    cnt0,
  output logic [15:0]    cnt1,
`endif
  output logic           busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic           rr_q;
  logic           gnt_id_q;
  logic [CW-1:0]  cnt_q;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic [OPW-1:0] op_q;
  logic           s_q;
  logic           r0_rvalid_q;
  logic           r1_rvalid_q;
  logic [DW:0]    r0_y_q;
  logic [DW:0]    r1_y_q;

  logic grant_c;
  logic hs_c;
  logic resp_hs_c;

  // Grant selection: a lone requester wins, a tie goes to the round-robin pointer
  always_comb begin
    grant_c = rr_q;
    if (r0_valid && !r1_valid) begin
      grant_c = 1'b0;
    end else if (!r0_valid && r1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign hs_c      = (state_q == ST_IDLE) && (r0_valid || r1_valid);
  assign r0_ready  = hs_c && !grant_c;
  assign r1_ready  = hs_c && grant_c;
  assign resp_hs_c = (state_q == ST_RESP) &&
                     (gnt_id_q ? (r1_rvalid_q && r1_rready) : (r0_rvalid_q && r0_rready));

  // Control FSM: accept op, hold datapath for DP_LAT+1 edges, return result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      gnt_id_q    <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      s_q         <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_y_q      <= '0;
      r1_y_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs_c) begin
            gnt_id_q <= grant_c;
            a_q      <= grant_c ? r1_a  : r0_a;
            b_q      <= grant_c ? r1_b  : r0_b;
            op_q     <= grant_c ? r1_op : r0_op;
            s_q      <= grant_c ? r1_s  : r0_s;
            cnt_q    <= CW'(DP_LAT);
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (gnt_id_q) begin
              r1_y_q      <= dp_y;
              r1_rvalid_q <= 1'b1;
            end else begin
              r0_y_q      <= dp_y;
              r0_rvalid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_RESP: begin
          // Result slots return to zero so the idle requester never sees stale data
          if (resp_hs_c) begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_y_q      <= '0;
            r1_y_q      <= '0;
            rr_q        <= ~gnt_id_q;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PATH_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  // Saturating count of completed responses per requester
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (resp_hs_c) begin
      if (!gnt_id_q && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (gnt_id_q && (cnt1_q != 16'hFFFF))  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

  assign dp_inA    = a_q;
  assign dp_inB    = b_q;
  assign dp_op     = op_q;
  assign dp_s      = s_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_y      = r0_y_q;
  assign r1_y      = r1_y_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_path_arbiter.sv
`timescale 1ns/1ps
// tb_path_arbiter: directed bench for path_arbiter.
// Three instances share requester inputs: DP_LAT=1 (main), DP_LAT=0 and DP_LAT=3.
// The datapath is modelled as a 9-bit add of the held operands.
module tb_path_arbiter;

  logic       clk;
  logic       rst;
  logic       r0_valid, r1_valid, r0_s, r1_s, r0_rready, r1_rready;
  logic [7:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0] r0_op, r1_op;

  logic       r0_ready, r1_ready, r0_rvalid, r1_rvalid, dp_s, busy;
  logic [8:0] r0_y, r1_y, dp_y;
  logic [7:0] dp_inA, dp_inB;
  logic [3:0] dp_op;

  logic       r0_ready_l0, r1_ready_l0, r0_rvalid_l0, r1_rvalid_l0, dp_s_l0, busy_l0;
  logic [8:0] r0_y_l0, r1_y_l0, dp_y_l0;
  logic [7:0] dp_inA_l0, dp_inB_l0;
  logic [3:0] dp_op_l0;

  logic       r0_ready_l3, r1_ready_l3, r0_rvalid_l3, r1_rvalid_l3, dp_s_l3, busy_l3;
  logic [8:0] r0_y_l3, r1_y_l3, dp_y_l3;
  logic [7:0] dp_inA_l3, dp_inB_l3;
  logic [3:0] dp_op_l3;

`ifdef PATH_ARB_STATS_EN
  logic [15:0] cnt0, cnt1, cnt0_l0, cnt1_l0, cnt0_l3, cnt1_l3;
`endif

  int tests_run;
  int tests_failed;

  assign dp_y    = 9'(dp_inA) + 9'(dp_inB);
  assign dp_y_l0 = 9'(dp_inA_l0) + 9'(dp_inB_l0);
  assign dp_y_l3 = 9'(dp_inA_l3) + 9'(dp_inB_l3);

  path_arbiter #(.DW(8), .OPW(4), .DP_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_s(r0_s),
    .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_y(r0_y),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_s(r1_s),
    .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_y(r1_y),
    .dp_inA(dp_inA), .dp_inB(dp_inB), .dp_op(dp_op), .dp_s(dp_s), .dp_y(dp_y),
`ifdef PATH_ARB_STATS_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .busy(busy)
  );

  path_arbiter #(.DW(8), .OPW(4), .DP_LAT(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready_l0), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_s(r0_s),
    .r0_rvalid(r0_rvalid_l0), .r0_rready(r0_rready), .r0_y(r0_y_l0),
    .r1_valid(r1_valid), .r1_ready(r1_ready_l0), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_s(r1_s),
    .r1_rvalid(r1_rvalid_l0), .r1_rready(r1_rready), .r1_y(r1_y_l0),
    .dp_inA(dp_inA_l0), .dp_inB(dp_inB_l0), .dp_op(dp_op_l0), .dp_s(dp_s_l0), .dp_y(dp_y_l0),
`ifdef PATH_ARB_STATS_EN
    .cnt0(cnt0_l0), .cnt1(cnt1_l0),
`endif
    .busy(busy_l0)
  );

  path_arbiter #(.DW(8), .OPW(4), .DP_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready_l3), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_s(r0_s),
    .r0_rvalid(r0_rvalid_l3), .r0_rready(r0_rready), .r0_y(r0_y_l3),
    .r1_valid(r1_valid), .r1_ready(r1_ready_l3), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_s(r1_s),
    .r1_rvalid(r1_rvalid_l3), .r1_rready(r1_rready), .r1_y(r1_y_l3),
    .dp_inA(dp_inA_l3), .dp_inB(dp_inB_l3), .dp_op(dp_op_l3), .dp_s(dp_s_l3), .dp_y(dp_y_l3),
`ifdef PATH_ARB_STATS_EN
    .cnt0(cnt0_l3), .cnt1(cnt1_l3),
`endif
    .busy(busy_l3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; r0_valid = 0; r1_valid = 0; r0_rready = 0; r1_rready = 0;
    r0_a = 0; r0_b = 0; r0_op = 0; r0_s = 0; r1_a = 0; r1_b = 0; r1_op = 0; r1_s = 0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b%b want 00", r0_rvalid, r1_rvalid); end
    tests_run++; if (r0_y !== 9'h000 || r1_y !== 9'h000) begin tests_failed++; $display("FAIL reset_y: got %h/%h want 000/000", r0_y, r1_y); end
    tests_run++; if (dp_inA !== 8'h00 || dp_inB !== 8'h00 || dp_op !== 4'h0 || dp_s !== 1'b0) begin tests_failed++; $display("FAIL reset_dp: got %h %h %h %b want zeros", dp_inA, dp_inB, dp_op, dp_s); end
    tests_run++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b%b want 00", r0_ready, r1_ready); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    r0_valid = 1; r0_a = 8'h0F; r0_b = 8'hF0; r0_op = 4'b0000; r0_s = 1;
    #1;
    tests_run++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin tests_failed++; $display("FAIL single_grant: got %b%b want 10", r0_ready, r1_ready); end
    @(negedge clk);
    r0_valid = 0;
    tests_run++; if (r0_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_wait: ready %b busy %b want 0 1", r0_ready, busy); end
    tests_run++; if (dp_inA !== 8'h0F || dp_inB !== 8'hF0 || dp_op !== 4'h0 || dp_s !== 1'b1) begin tests_failed++; $display("FAIL single_dp: got %h %h %h %b want 0f f0 0 1", dp_inA, dp_inB, dp_op, dp_s); end
    tests_run++; if (r0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_early1: rvalid %b want 0", r0_rvalid); end
    @(negedge clk);
    tests_run++; if (r0_rvalid !== 1'b0 || dp_inA !== 8'h0F) begin tests_failed++; $display("FAIL single_early2: rvalid %b dpA %h want 0 0f", r0_rvalid, dp_inA); end
    @(negedge clk);
    tests_run++; if (r0_rvalid !== 1'b1 || r0_y !== 9'h0FF) begin tests_failed++; $display("FAIL single_result: rvalid %b y %h want 1 0ff", r0_rvalid, r0_y); end
    tests_run++; if (r1_rvalid !== 1'b0 || r1_y !== 9'h000) begin tests_failed++; $display("FAIL single_other: rvalid %b y %h want 0 000", r1_rvalid, r1_y); end
    r0_rready = 1;
    @(negedge clk);
    tests_run++; if (r0_rvalid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_ack: rvalid %b busy %b want 0 0", r0_rvalid, busy); end
    tests_run++; if (dp_inA !== 8'h0F || dp_inB !== 8'hF0) begin tests_failed++; $display("FAIL single_dp_hold: got %h %h want 0f f0", dp_inA, dp_inB); end
    r0_rready = 0;
  endtask

  task automatic test_round_robin();
    do_reset();
    r0_valid = 1; r0_a = 8'h0F; r0_b = 8'hF0; r0_op = 4'h0; r0_s = 0;
    r1_valid = 1; r1_a = 8'hFF; r1_b = 8'h01; r1_op = 4'h0; r1_s = 0;
    r0_rready = 1; r1_rready = 1;
    #1;
    tests_run++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin tests_failed++; $display("FAIL rr_first: got %b%b want 10", r0_ready, r1_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (r1_ready !== 1'b0 || r0_ready !== 1'b0) begin tests_failed++; $display("FAIL rr_pending[%0d]: got %b%b want 00", k, r0_ready, r1_ready); end
    end
    tests_run++; if (r0_rvalid !== 1'b1 || r0_y !== 9'h0FF) begin tests_failed++; $display("FAIL rr_r0_result: rvalid %b y %h want 1 0ff", r0_rvalid, r0_y); end
    @(negedge clk);
    tests_run++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin tests_failed++; $display("FAIL rr_second: got %b%b want 01", r0_ready, r1_ready); end
    @(negedge clk);
    tests_run++; if (dp_inA !== 8'hFF || dp_inB !== 8'h01) begin tests_failed++; $display("FAIL rr_r1_dp: got %h %h want ff 01", dp_inA, dp_inB); end
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (r1_rvalid !== 1'b1 || r1_y !== 9'h100) begin tests_failed++; $display("FAIL rr_r1_carry: rvalid %b y %h want 1 100", r1_rvalid, r1_y); end
    tests_run++; if (r0_rvalid !== 1'b0 || r0_y !== 9'h000) begin tests_failed++; $display("FAIL rr_r0_quiet: rvalid %b y %h want 0 000", r0_rvalid, r0_y); end
    @(negedge clk);
    tests_run++; if (r1_rvalid !== 1'b0 || r0_ready !== 1'b1 || r1_ready !== 1'b0) begin tests_failed++; $display("FAIL rr_third: rvalid %b ready %b%b want 0 10", r1_rvalid, r0_ready, r1_ready); end
    r0_valid = 0; r1_valid = 0; r0_rready = 0; r1_rready = 0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    r0_valid = 1; r0_a = 8'h12; r0_b = 8'h34; r0_s = 0;
    @(negedge clk);
    r0_valid = 0;
    r1_valid = 1; r1_a = 8'h01; r1_b = 8'h01;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (r0_rvalid !== 1'b1 || r0_y !== 9'h046 || busy !== 1'b1 || r1_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: rvalid %b y %h busy %b r1_ready %b want 1 046 1 0", k, r0_rvalid, r0_y, busy, r1_ready);
      end
      @(negedge clk);
    end
    r0_rready = 1;
    @(negedge clk);
    tests_run++; if (r0_rvalid !== 1'b0 || r1_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release: rvalid %b r1_ready %b want 0 1", r0_rvalid, r1_ready); end
    r0_rready = 0; r1_valid = 0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    r0_valid = 1; r0_a = 8'h55; r0_b = 8'h22; r0_s = 1;
    @(negedge clk);
    r0_valid = 0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL arst_pre: busy %b want 1", busy); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || r0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL arst_ctrl: busy %b rvalid %b want 0 0", busy, r0_rvalid); end
    tests_run++; if (dp_inA !== 8'h00 || dp_inB !== 8'h00 || dp_s !== 1'b0) begin tests_failed++; $display("FAIL arst_dp: got %h %h %b want 00 00 0", dp_inA, dp_inB, dp_s); end
    @(negedge clk);
    rst = 1'b1;
    r0_valid = 1; r1_valid = 1; r1_a = 8'h03; r1_b = 8'h04; r1_rready = 1;
    #1;
    tests_run++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin tests_failed++; $display("FAIL arst_ptr: got %b%b want 10", r0_ready, r1_ready); end
    r0_valid = 0;
    #1;
    tests_run++; if (r1_ready !== 1'b1) begin tests_failed++; $display("FAIL arst_r1_grant: got %b want 1", r1_ready); end
    @(negedge clk);
    r1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (r1_rvalid !== 1'b1 || r1_y !== 9'h007 || r0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL arst_r1_result: rvalid %b y %h r0_rvalid %b want 1 007 0", r1_rvalid, r1_y, r0_rvalid); end
    @(negedge clk);
    tests_run++; if (r1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL arst_r1_ack: rvalid %b want 0", r1_rvalid); end
    r1_rready = 0;
  endtask

  task automatic test_latency();
    do_reset();
    r0_rready = 1; r1_rready = 1;
    r0_valid = 1; r0_a = 8'h10; r0_b = 8'h20; r0_op = 4'h0; r0_s = 0;
    #1;
    tests_run++; if (r0_ready_l0 !== 1'b1 || r0_ready_l3 !== 1'b1) begin tests_failed++; $display("FAIL lat_grant: got %b%b want 11", r0_ready_l0, r0_ready_l3); end
    @(negedge clk);
    r0_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests_run++; if (r0_rvalid_l0 !== 1'(k == 1)) begin tests_failed++; $display("FAIL lat0_rvalid[%0d]: got %b want %b", k, r0_rvalid_l0, (k == 1)); end
      tests_run++; if (r0_rvalid !== 1'(k == 2)) begin tests_failed++; $display("FAIL lat1_rvalid[%0d]: got %b want %b", k, r0_rvalid, (k == 2)); end
      tests_run++; if (r0_rvalid_l3 !== 1'(k == 4)) begin tests_failed++; $display("FAIL lat3_rvalid[%0d]: got %b want %b", k, r0_rvalid_l3, (k == 4)); end
      if (k <= 3) begin
        tests_run++; if (dp_inA_l3 !== 8'h10 || dp_inB_l3 !== 8'h20) begin tests_failed++; $display("FAIL lat3_dp[%0d]: got %h %h want 10 20", k, dp_inA_l3, dp_inB_l3); end
      end
      if (k == 1) begin
        tests_run++; if (r0_y_l0 !== 9'h030) begin tests_failed++; $display("FAIL lat0_y: got %h want 030", r0_y_l0); end
      end
      if (k == 4) begin
        tests_run++; if (r0_y_l3 !== 9'h030) begin tests_failed++; $display("FAIL lat3_y: got %h want 030", r0_y_l3); end
      end
    end
    r0_rready = 0; r1_rready = 0;
  endtask

`ifdef PATH_ARB_STATS_EN
  task automatic do_op(input bit req, input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    if (req) begin r1_valid = 1; r1_a = a; r1_b = b; end
    else     begin r0_valid = 1; r0_a = a; r0_b = b; end
    n = 0;
    #1;
    while (!(req ? r1_ready : r0_ready) && n < 20) begin @(negedge clk); #1; n++; end
    tests_run++; if (n >= 20) begin tests_failed++; $display("FAIL stats_ready_timeout: req %0d waited %0d want <20", req, n); end
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    n = 0;
    while (!(req ? r1_rvalid : r0_rvalid) && n < 20) begin @(negedge clk); n++; end
    tests_run++;
    if ((req ? r1_y : r0_y) !== 9'(a) + 9'(b)) begin
      tests_failed++;
      $display("FAIL stats_op_y: req %0d got %h want %h", req, (req ? r1_y : r0_y), 9'(a) + 9'(b));
    end
    @(negedge clk);
  endtask

  task automatic test_stats();
    do_reset();
    r0_rready = 1; r1_rready = 1;
    do_op(1'b0, 8'h01, 8'h02);
    do_op(1'b1, 8'h80, 8'h80);
    do_op(1'b0, 8'h7F, 8'h01);
    do_op(1'b1, 8'h11, 8'h22);
    do_op(1'b0, 8'hFE, 8'hFE);
    tests_run++; if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin tests_failed++; $display("FAIL stats_count: got %0d/%0d want 3/2", cnt0, cnt1); end
    rst = 1'b0;
    #1;
    tests_run++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin tests_failed++; $display("FAIL stats_reset: got %0d/%0d want 0/0", cnt0, cnt1); end
    @(negedge clk);
    rst = 1'b1;
    r0_rready = 0; r1_rready = 0;
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_latency();
`ifdef PATH_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
